// File: rtl/vga_pkg.sv
// Shared VGA constants, width helper and the rectangle sequencer state type.
package vga_pkg;

  localparam int H_RES_640 = 640;
  localparam int V_RES_480 = 480;
  localparam int H_RES_320 = 320;
  localparam int V_RES_240 = 240;
  localparam int H_RES_160 = 160;
  localparam int V_RES_120 = 120;

  typedef enum logic [1:0] {IDLE, MUL, RUN, FIN} vga_state_t;

  // Never returns 0 so a 1-pixel resolution still gets a 1-bit field.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/vga_rect_address_gen_if.sv
// Address beat stream from the rectangle sequencer to the video-memory write port.
interface vga_rect_address_gen_if
  import vga_pkg::*;
#(
  parameter int X_W    = clog2(H_RES_640),
  parameter int Y_W    = clog2(V_RES_480),
  parameter int ADDR_W = clog2(H_RES_640 * V_RES_480)
);
  logic              out_valid;
  logic              out_ready;
  logic [X_W-1:0]    out_x;
  logic [Y_W-1:0]    out_y;
  logic [ADDR_W-1:0] out_addr;

  modport master (output out_valid, out_x, out_y, out_addr, input out_ready);
  modport slave  (input out_valid, out_x, out_y, out_addr, output out_ready);
endinterface

// File: rtl/vga_row_base_mul.sv
// Sequential shift-add multiply of y0 by the constant H_RES, MSB first, one bit per cycle.
module vga_row_base_mul
  import vga_pkg::*;
#(
  parameter int H_RES = H_RES_640,
  parameter int Y_W   = 9,
  parameter int P_W   = 20
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           i_start,
  input  logic [Y_W-1:0] i_mplier,
  output logic           o_done,
  output logic [P_W-1:0] o_prod
);
  localparam int C_W = clog2(Y_W + 1);

  logic [C_W-1:0] r_cnt;
  logic [Y_W-1:0] r_mplier;
  logic [P_W-1:0] r_acc;
  logic [P_W-1:0] w_acc_nxt;

  assign w_acc_nxt = (r_acc << 1) + (r_mplier[Y_W-1] ? P_W'(H_RES) : P_W'(0));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt    <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_start) begin
      r_cnt    <= C_W'(Y_W);
      r_mplier <= i_mplier;
      r_acc    <= '0;
    end else if (r_cnt != '0) begin
      r_cnt    <= r_cnt - C_W'(1);
      r_mplier <= r_mplier << 1;
      r_acc    <= w_acc_nxt;
    end
  end

  // The product is presented combinationally during the final step cycle.
  assign o_done = (r_cnt == C_W'(1));
  assign o_prod = w_acc_nxt;

endmodule

// File: rtl/vga_rect_address_gen.sv
// Rectangle frame-buffer address sequencer; optional clipping with VGA_RECT_CLIP_EN.
// state | meaning
// IDLE  | waiting for start
// MUL   | computing y0*H_RES
// RUN   | streaming one address per pixel
// FIN   | one-cycle done pulse
module vga_rect_address_gen
  import vga_pkg::*;
#(
  parameter int H_RES  = H_RES_640,
  parameter int V_RES  = V_RES_480,
  parameter int X_W    = clog2(H_RES),
  parameter int Y_W    = clog2(V_RES),
  parameter int ADDR_W = clog2(H_RES * V_RES)
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           i_start,
  input  logic [X_W-1:0] i_x0,
  input  logic [Y_W-1:0] i_y0,
  input  logic [X_W:0]   i_w,
  input  logic [Y_W:0]   i_h,
  output logic           o_busy,
  output logic           o_done,
  vga_rect_address_gen_if.master out_if
);
  vga_state_t      r_state, w_state_nxt;
  logic [X_W-1:0]  r_x0, r_cx;
  logic [Y_W-1:0]  r_cy;
  logic [X_W:0]    r_w, r_col_left, w_w_eff;
  logic [Y_W:0]    r_row_left, w_h_eff;
  logic [ADDR_W:0] r_row_base, w_prod;
  logic            w_mul_start, w_mul_done, w_fire, w_empty, w_last_col, w_last_row;

`ifdef VGA_RECT_CLIP_EN
  always_comb begin
    w_w_eff = i_w;
    w_h_eff = i_h;
    if (int'(i_x0) >= H_RES || int'(i_y0) >= V_RES) begin
      w_w_eff = '0;
      w_h_eff = '0;
    end else begin
      if (int'(i_w) > H_RES - int'(i_x0)) w_w_eff = (X_W+1)'(H_RES - int'(i_x0));
      if (int'(i_h) > V_RES - int'(i_y0)) w_h_eff = (Y_W+1)'(V_RES - int'(i_y0));
    end
  end
`else
  assign w_w_eff = i_w;
  assign w_h_eff = i_h;
`endif

  assign w_empty    = (w_w_eff == '0) || (w_h_eff == '0);
  assign w_fire     = (r_state == RUN) && out_if.out_ready;
  assign w_last_col = (r_col_left == (X_W+1)'(1));
  assign w_last_row = (r_row_left == (Y_W+1)'(1));

  vga_row_base_mul #(.H_RES(H_RES), .Y_W(Y_W), .P_W(ADDR_W + 1)) u_mul (
    .clock    (clock),
    .resetn   (resetn),
    .i_start  (w_mul_start),
    .i_mplier (i_y0),
    .o_done   (w_mul_done),
    .o_prod   (w_prod)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_mul_start      = 1'b0;
    o_busy           = (r_state != IDLE);
    o_done           = 1'b0;
    out_if.out_valid = 1'b0;
    case (r_state)
      IDLE: if (i_start) begin
        if (w_empty) begin
          w_state_nxt = FIN;
        end else begin
          w_state_nxt = MUL;
          w_mul_start = 1'b1;
        end
      end
      MUL: if (w_mul_done) w_state_nxt = RUN;
      RUN: begin
        out_if.out_valid = 1'b1;
        if (w_fire && w_last_col && w_last_row) w_state_nxt = FIN;
      end
      FIN: begin
        o_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_x0       <= '0;
      r_cx       <= '0;
      r_cy       <= '0;
      r_w        <= '0;
      r_col_left <= '0;
      r_row_left <= '0;
      r_row_base <= '0;
    end else begin
      if (r_state == IDLE && i_start) begin
        r_x0       <= i_x0;
        r_cx       <= i_x0;
        r_cy       <= i_y0;
        r_w        <= w_w_eff;
        r_col_left <= w_w_eff;
        r_row_left <= w_h_eff;
      end
      if (r_state == MUL && w_mul_done) r_row_base <= w_prod;
      if (w_fire) begin
        if (w_last_col) begin
          r_cx       <= r_x0;
          r_col_left <= r_w;
          r_cy       <= r_cy + Y_W'(1);
          r_row_left <= r_row_left - (Y_W+1)'(1);
          r_row_base <= r_row_base + (ADDR_W+1)'(H_RES);
        end else begin
          r_cx       <= r_cx + X_W'(1);
          r_col_left <= r_col_left - (X_W+1)'(1);
        end
      end
    end
  end

  assign out_if.out_x    = r_cx;
  assign out_if.out_y    = r_cy;
  assign out_if.out_addr = ADDR_W'(r_row_base + (ADDR_W+1)'(r_cx));

endmodule

// File: tb/tb_vga_rect_address_gen.sv
// Bench for vga_rect_address_gen at 640x480 (scoreboarded) and 320x240.
module tb_vga_rect_address_gen;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [9:0]  x0 = '0;
  logic [8:0]  y0 = '0;
  logic [10:0] w = '0;
  logic [9:0]  h = '0;
  logic        busy, done;
  vga_rect_address_gen_if #(.X_W(10), .Y_W(9), .ADDR_W(19)) vif();

  vga_rect_address_gen #(.H_RES(640), .V_RES(480)) dut (
    .clock(clk), .resetn(resetn), .i_start(start), .i_x0(x0), .i_y0(y0),
    .i_w(w), .i_h(h), .o_busy(busy), .o_done(done), .out_if(vif)
  );

  logic        start2 = 1'b0;
  logic [8:0]  x0_2 = '0;
  logic [7:0]  y0_2 = '0;
  logic [9:0]  w_2 = '0;
  logic [8:0]  h_2 = '0;
  logic        busy2, done2;
  vga_rect_address_gen_if #(.X_W(9), .Y_W(8), .ADDR_W(17)) vif2();

  vga_rect_address_gen #(.H_RES(320), .V_RES(240)) dut2 (
    .clock(clk), .resetn(resetn), .i_start(start2), .i_x0(x0_2), .i_y0(y0_2),
    .i_w(w_2), .i_h(h_2), .o_busy(busy2), .o_done(done2), .out_if(vif2)
  );

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [18:0] addr;
  } beat_t;

  beat_t exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int beats = 0;
  int last_hs = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic watch_beats();
    beat_t e;
    forever begin
      @(negedge clk);
      if (resetn && vif.out_valid && vif.out_ready) begin
        beats++;
        last_hs = cyc;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL beat_unexpected got x=%0d y=%0d addr=%0d, no beat expected",
                   vif.out_x, vif.out_y, vif.out_addr);
        end else begin
          e = exp_q.pop_front();
          if ({vif.out_x, vif.out_y, vif.out_addr} !== e) begin
            bad++;
            $display("FAIL beat got x=%0d y=%0d addr=%0d, want x=%0d y=%0d addr=%0d",
                     vif.out_x, vif.out_y, vif.out_addr, e.x, e.y, e.addr);
          end
        end
      end
    end
  endtask

  task automatic push_rect(input int px, input int py, input int pw, input int ph);
    beat_t b;
    int ew, eh;
    ew = pw;
    eh = ph;
`ifdef VGA_RECT_CLIP_EN
    if (px >= 640 || py >= 480) begin
      ew = 0;
      eh = 0;
    end else begin
      if (ew > 640 - px) ew = 640 - px;
      if (eh > 480 - py) eh = 480 - py;
    end
`endif
    for (int r = 0; r < eh; r++) begin
      for (int c = 0; c < ew; c++) begin
        b.x    = 10'((px + c) % 1024);
        b.y    = 9'((py + r) % 512);
        b.addr = 19'(((py + r) * 640 + ((px + c) % 1024)) % 524288);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic start_rect(input int px, input int py, input int pw, input int ph, output int k);
    @(posedge clk); #1;
    x0 = 10'(px); y0 = 9'(py); w = 11'(pw); h = 10'(ph);
    start = 1'b1;
    k = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    x0 = 10'($urandom); y0 = 9'($urandom); w = 11'($urandom); h = 10'($urandom);
  endtask

  task automatic wait_valid(output int vc);
    vc = -1;
    for (int i = 0; i < 100 && vc < 0; i++) begin
      @(negedge clk);
      if (vif.out_valid) vc = cyc;
    end
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 200 && dc < 0; i++) begin
      @(negedge clk);
      if (done) dc = cyc;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    vif.out_ready = 1'b1;
    vif2.out_ready = 1'b1;
    #12;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
    total++; if (vif.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", vif.out_valid); end
    total++; if (vif.out_x !== 10'd0 || vif.out_y !== 9'd0) begin
      bad++; $display("FAIL reset_xy got %0d,%0d want 0,0", vif.out_x, vif.out_y); end
    total++; if (vif.out_addr !== 19'd0) begin bad++; $display("FAIL reset_addr got %0d want 0", vif.out_addr); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    int k, vc, dc;
    beats = 0;
    vif.out_ready = 1'b1;
    push_rect(10, 2, 3, 2);
    start_rect(10, 2, 3, 2, k);
    wait_valid(vc);
    total++; if (vc != k + 10) begin bad++; $display("FAIL basic_latency got cycle %0d want %0d", vc, k + 10); end
    wait_done(dc);
    total++; if (dc < 0 || dc != last_hs + 1) begin
      bad++; $display("FAIL basic_done_cycle got %0d want %0d", dc, last_hs + 1); end
    total++; if (beats != 6 || exp_q.size() != 0) begin
      bad++; $display("FAIL basic_beats got %0d left %0d want 6 left 0", beats, exp_q.size()); end
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL basic_after_done got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_backpressure();
    int k, vc, dc;
    beats = 0;
    vif.out_ready = 1'b1;
    push_rect(10, 2, 3, 2);
    start_rect(10, 2, 3, 2, k);
    wait_valid(vc);
    @(posedge clk); #1;
    vif.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (vif.out_valid !== 1'b1 || vif.out_addr !== 19'd1291) begin
        bad++; $display("FAIL bp_hold got valid=%b addr=%0d want 1 1291", vif.out_valid, vif.out_addr); end
      @(posedge clk); #1;
    end
    vif.out_ready = 1'b1;
    wait_done(dc);
    total++; if (dc < 0 || beats != 6 || exp_q.size() != 0) begin
      bad++; $display("FAIL bp_beats got %0d left %0d done %0d want 6 left 0", beats, exp_q.size(), dc); end
  endtask

  task automatic test_zero_and_busy_start();
    int k, nv, nd;
    beats = 0;
    vif.out_ready = 1'b1;
    start_rect(7, 3, 0, 5, k);
    x0 = 10'd1; y0 = 9'd1; w = 11'd2; h = 10'd2; start = 1'b1;
    @(negedge clk);
    total++; if (done !== 1'b1 || busy !== 1'b1 || cyc != k + 1) begin
      bad++; $display("FAIL zero_done got done=%b busy=%b cycle %0d want 1 1 %0d", done, busy, cyc, k + 1); end
    @(posedge clk); #1;
    start = 1'b0;
    nv = 0; nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (vif.out_valid) nv++;
      if (done) nd++;
    end
    total++; if (nv != 0 || nd != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL zero_quiet got valid=%0d done=%0d busy=%b want 0 0 0", nv, nd, busy); end
  endtask

  task automatic test_back_to_back();
    int k, vc, dc;
    beats = 0;
    vif.out_ready = 1'b1;
    push_rect(5, 1, 2, 1);
    start_rect(5, 1, 2, 1, k);
    wait_done(dc);
    push_rect(100, 400, 2, 2);
    start_rect(100, 400, 2, 2, k);
    total++; if (k != dc + 1) begin bad++; $display("FAIL b2b_start_cycle got %0d want %0d", k, dc + 1); end
    wait_valid(vc);
    total++; if (vc != k + 10) begin bad++; $display("FAIL b2b_latency got %0d want %0d", vc, k + 10); end
    wait_done(dc);
    total++; if (dc < 0 || beats != 6 || exp_q.size() != 0) begin
      bad++; $display("FAIL b2b_beats got %0d left %0d want 6 left 0", beats, exp_q.size()); end
  endtask

  task automatic test_edge_rect();
    int k, dc, want;
`ifdef VGA_RECT_CLIP_EN
    want = 2;
`else
    want = 12;
`endif
    beats = 0;
    vif.out_ready = 1'b1;
    push_rect(638, 479, 4, 3);
    start_rect(638, 479, 4, 3, k);
    wait_done(dc);
    total++; if (dc < 0 || beats != want || exp_q.size() != 0) begin
      bad++; $display("FAIL edge_beats got %0d left %0d want %0d left 0", beats, exp_q.size(), want); end
  endtask

  task automatic test_small_res();
    int k, vc;
    @(posedge clk); #1;
    x0_2 = 9'd319; y0_2 = 8'd239; w_2 = 10'd1; h_2 = 9'd1; start2 = 1'b1;
    k = cyc;
    @(posedge clk); #1;
    start2 = 1'b0; x0_2 = '0; y0_2 = '0;
    vc = -1;
    for (int i = 0; i < 100 && vc < 0; i++) begin
      @(negedge clk);
      if (vif2.out_valid) vc = cyc;
    end
    total++; if (vc != k + 9) begin bad++; $display("FAIL small_latency got %0d want %0d", vc, k + 9); end
    total++; if (vif2.out_addr !== 17'd76799 || vif2.out_x !== 9'd319 || vif2.out_y !== 8'd239) begin
      bad++; $display("FAIL small_beat got x=%0d y=%0d addr=%0d want 319 239 76799",
                      vif2.out_x, vif2.out_y, vif2.out_addr); end
    @(negedge clk);
    total++; if (done2 !== 1'b1 || vif2.out_valid !== 1'b0) begin
      bad++; $display("FAIL small_done got done=%b valid=%b want 1 0", done2, vif2.out_valid); end
  endtask

  task automatic test_reset_abort();
    int k, vc, dc, nd, nv;
    beats = 0;
    vif.out_ready = 1'b1;
    push_rect(10, 2, 3, 2);
    start_rect(10, 2, 3, 2, k);
    for (int i = 0; i < 100 && beats < 2; i++) @(negedge clk);
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    total++; if (vif.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
                 vif.out_x !== 10'd0 || vif.out_y !== 9'd0 || vif.out_addr !== 19'd0 || beats != 2) begin
      bad++; $display("FAIL abort_async got valid=%b busy=%b done=%b x=%0d y=%0d addr=%0d beats=%0d want all 0, beats 2",
                      vif.out_valid, busy, done, vif.out_x, vif.out_y, vif.out_addr, beats); end
    exp_q.delete();
    nd = 0; nv = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) nd++;
      if (vif.out_valid) nv++;
    end
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) nd++;
      if (vif.out_valid) nv++;
    end
    total++; if (nd != 0 || nv != 0) begin
      bad++; $display("FAIL abort_quiet got done=%0d valid=%0d want 0 0", nd, nv); end
    beats = 0;
    push_rect(10, 2, 3, 2);
    start_rect(10, 2, 3, 2, k);
    wait_valid(vc);
    total++; if (vc != k + 10) begin bad++; $display("FAIL abort_restart_latency got %0d want %0d", vc, k + 10); end
    wait_done(dc);
    total++; if (dc < 0 || beats != 6 || exp_q.size() != 0) begin
      bad++; $display("FAIL abort_restart_beats got %0d left %0d want 6 left 0", beats, exp_q.size()); end
  endtask

  initial begin
    fork
      watch_beats();
    join_none
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_and_busy_start();
    test_back_to_back();
    test_edge_rect();
    test_small_res();
    test_reset_abort();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
